// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C byte-transfer driver between
// N_REQ clients. One client is granted per transfer; its command is frozen
// onto the driver interface and the result is returned to that client only.
// Optional watchdog on the WAIT state is compiled in with I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
   parameter int unsigned N_REQ       = 2,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_vld,
   input  logic [16*N_REQ-1:0]  req_addr,
   input  logic [8*N_REQ-1:0]   req_data_w,
   input  logic [N_REQ-1:0]     req_rh_wl,
   output logic [N_REQ-1:0]     req_done,
   output logic                 req_ack,
   output logic [7:0]           req_data_r,
   output logic                 i2c_exec,
   output logic [15:0]          i2c_addr,
   output logic [7:0]           i2c_data_w,
   output logic                 i2c_rh_wl,
   input  logic                 i2c_done,
   input  logic                 i2c_ack,
   input  logic [7:0]           i2c_data_r,
   output logic                 busy,
   output logic [2:0]           grant_id,
   output logic                 timeout
);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
      $error("i2c_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC must fit 16 bits");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state_q;
   logic [2:0]       rr_q;
   logic [2:0]       grant_q;
   logic             exec_q;
   logic [15:0]      addr_q;
   logic [7:0]       data_w_q;
   logic             rh_wl_q;
   logic [N_REQ-1:0] done_q;
   logic             ack_q;
   logic [7:0]       data_r_q;
   logic             busy_q;

   logic             win_vld;
   logic [2:0]       win_idx;
   logic [15:0]      sel_addr;
   logic [7:0]       sel_data_w;
   logic             sel_rh_wl;
   logic [N_REQ-1:0] done_onehot;

`ifdef I2C_ARB_TIMEOUT_EN
   logic [15:0]      wait_cnt_q;
   logic             timeout_q;
`endif

   // Round-robin search: first requester strictly after the last winner, wrapping.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!win_vld && (k == (32'(rr_q) + i) % N_REQ) && req_vld[k]) begin
               win_vld = 1'b1;
               win_idx = 3'(k);
            end
         end
      end
   end

   // Command mux for the winner, and one-hot completion vector for the current grant.
   always_comb begin
      sel_addr    = '0;
      sel_data_w  = '0;
      sel_rh_wl   = 1'b0;
      done_onehot = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (win_idx == 3'(k)) begin
            sel_addr   = req_addr[16*k +: 16];
            sel_data_w = req_data_w[8*k +: 8];
            sel_rh_wl  = req_rh_wl[k];
         end
         done_onehot[k] = (grant_q == 3'(k));
      end
   end

   // Transfer FSM with registered outputs. req_done is raised on the WAIT->RESP
   // edge so it is visible during RESP; a client dropping req_vld right after
   // seeing it is therefore never re-granted by the following IDLE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_q     <= 3'(N_REQ - 1);
         grant_q  <= '0;
         exec_q   <= 1'b0;
         addr_q   <= '0;
         data_w_q <= '0;
         rh_wl_q  <= 1'b0;
         done_q   <= '0;
         ack_q    <= 1'b0;
         data_r_q <= '0;
         busy_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         exec_q <= 1'b0;
         done_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (win_vld) begin
                  grant_q  <= win_idx;
                  rr_q     <= win_idx;
                  addr_q   <= sel_addr;
                  data_w_q <= sel_data_w;
                  rh_wl_q  <= sel_rh_wl;
                  busy_q   <= 1'b1;
                  state_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               exec_q  <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (i2c_done) begin
                  ack_q    <= i2c_ack;
                  data_r_q <= i2c_data_r;
                  done_q   <= done_onehot;
                  state_q  <= S_RESP;
               end
`ifdef I2C_ARB_TIMEOUT_EN
               else if (wait_cnt_q == 16'(TIMEOUT_CYC)) begin
                  ack_q     <= 1'b1;
                  data_r_q  <= 8'hFF;
                  done_q    <= done_onehot;
                  timeout_q <= 1'b1;
                  state_q   <= S_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 16'd1;
               end
`endif
            end
            S_RESP: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_done   = done_q;
   assign req_ack    = ack_q;
   assign req_data_r = data_r_q;
   assign i2c_exec   = exec_q;
   assign i2c_addr   = addr_q;
   assign i2c_data_w = data_w_q;
   assign i2c_rh_wl  = rh_wl_q;
   assign busy       = busy_q;
   assign grant_id   = grant_q;
`ifdef I2C_ARB_TIMEOUT_EN
   assign timeout    = timeout_q;
`else
   assign timeout    = 1'b0;
`endif

endmodule
